// File: rtl/sweep_frame_packer.sv
// sweep_frame_packer
//   Captures one A-line sweep of real ADC samples per sweep trigger into a
//   FIFO and emits them as FFTPTS-sample Avalon-ST packets (sop/eop framed)
//   for the BFP/IFFT stage. A trigger is only admitted when the FIFO has room
//   for a whole frame, so downstream never sees a truncated packet.
//   Optional feature macro: SWEEP_FRAME_PACKER_TESTPAT_EN adds a test_mode
//   input that replaces adc_data with a per-frame sample-index ramp.
module sweep_frame_packer #(
  parameter int DATA_W     = 16,
  parameter int FFTPTS     = 256,
  parameter int FIFO_DEPTH = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              sweep_trig,
  input  logic              source_ready,
  output logic              source_valid,
  output logic              source_sop,
  output logic              source_eop,
  output logic [DATA_W-1:0] source_real,
  output logic [DATA_W-1:0] source_imag,
  output logic [1:0]        source_error,
  output logic              busy,
  output logic [15:0]       frames_dropped
`ifdef SWEEP_FRAME_PACKER_TESTPAT_EN
  ,
  input  logic              test_mode
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FFTPTS);
  localparam int WORD_W = DATA_W + 2;

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FRAME_C = (PTR_W+1)'(FFTPTS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(FFTPTS - 1);

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cur_cnt;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    occ_after_rd;
  logic [PTR_W:0]    free_entries;
  logic              admit;

  logic              wr_en;
  logic              rd_en;
  logic              drop_inc;
  logic [DATA_W-1:0] wr_data;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  // The sample index of the current write; an accepted trigger cycle is sample 0.
  assign cur_cnt = (state_q == IDLE) ? '0 : cnt_q;

`ifdef SWEEP_FRAME_PACKER_TESTPAT_EN
  assign wr_data = test_mode ? DATA_W'(cur_cnt) : adc_data;
`else
  assign wr_data = adc_data;
`endif

  assign wr_word = {(cur_cnt == '0), (cur_cnt == LAST_C), wr_data};

  // The output register pulls a new entry whenever it is empty or being drained.
  assign rd_en = (count_q != '0) && (!source_valid || source_ready);

  // Free space is judged after this cycle's read so a draining FIFO admits early.
  assign occ_after_rd = count_q - {{PTR_W{1'b0}}, rd_en};
  assign free_entries = DEPTH_C - occ_after_rd;
  assign admit        = (free_entries >= FRAME_C);

  assign busy         = (state_q == CAPTURE);
  assign source_imag  = '0;
  assign source_error = 2'b00;

  // Capture FSM next-state: trigger admission in IDLE, sample counting in CAPTURE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sweep_trig) begin
          if (admit) begin
            state_d = CAPTURE;
            cnt_d   = '0;
            if (adc_valid) begin
              wr_en = 1'b1;
              cnt_d = CNT_W'(1);
            end
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_C) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture FSM state and sample counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  assign rd_word = mem[rd_ptr_q];

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Output register: holds while stalled, reloads or empties on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_real  <= '0;
    end else if (rd_en) begin
      source_valid <= 1'b1;
      source_sop   <= rd_word[WORD_W-1];
      source_eop   <= rd_word[WORD_W-2];
      source_real  <= rd_word[DATA_W-1:0];
    end else if (source_ready) begin
      source_valid <= 1'b0;
    end
  end

  // Refused-trigger counter, saturating so it never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_dropped <= '0;
    end else if (drop_inc && (frames_dropped != 16'hFFFF)) begin
      frames_dropped <= frames_dropped + 16'd1;
    end
  end

endmodule
